// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer driving datapath control inputs
//
// Ports:
//   clk, clr (async active-low reset)
//   ir[31:0]   instruction register contents; opcode is ir[31:27]
//   con_out    branch-condition flag from the datapath
//   *_out      bus drive selects (at most one high per step)
//   *_enable, r_in   register loads
//   pc_increment, read, ram_write, gra, grb, grc   misc control
//   run        high while executing; low in reset and after halt
//   step[3:0]  current step code (T0..T7 = 0..7, HALT = 15)
module control_unit #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_out,
  output logic        pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out,
  output logic        inport_out, c_sign_extended_out, ba_out, r_out,
  output logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
  output logic        pc_enable, hi_enable, lo_enable, r15_enable,
  output logic        outport_enable, inport_enable, con_enable, r_in,
  output logic        pc_increment, read, ram_write, gra, grb, grc,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd15
  } step_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

  step_t          state, state_next;
  logic           run_q;
  logic [OPW-1:0] op;
  logic           unused_ir;

  assign op        = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  // Final step of each instruction; nop and unknown opcodes end after fetch.
  function automatic step_t last_step(input logic [OPW-1:0] o);
    case (o)
      OP_LD, OP_ST:                           last_step = T7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI:                                last_step = T5;
      OP_BR:                                  last_step = T6;
      OP_JAL:                                 last_step = T4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_step = T3;
      default:                                last_step = T2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= T0;
      run_q <= 1'b0;
    end else begin
      state <= state_next;
      run_q <= (state_next != HALT);
    end
  end

  // The first edge after reset release only arms run_q and stays in T0.
  // The T2 decision uses the opcode presented on ir during fetch.
  always_comb begin
    state_next = state;
    if (state == HALT)
      state_next = HALT;
    else if (!run_q)
      state_next = T0;
    else if (state == T2 && op == OP_HALT)
      state_next = HALT;
    else if (state == last_step(op))
      state_next = T0;
    else
      state_next = step_t'(state + 4'd1);
  end

  always_comb begin
    pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
    mdr_out = 1'b0; inport_out = 1'b0; c_sign_extended_out = 1'b0; ba_out = 1'b0;
    r_out = 1'b0; mar_enable = 1'b0; mdr_enable = 1'b0; ir_enable = 1'b0;
    y_enable = 1'b0; z_enable = 1'b0; pc_enable = 1'b0; hi_enable = 1'b0;
    lo_enable = 1'b0; r15_enable = 1'b0; outport_enable = 1'b0;
    inport_enable = 1'b0; con_enable = 1'b0; r_in = 1'b0; pc_increment = 1'b0;
    read = 1'b0; ram_write = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    step = state;
    // clr gates combinationally so every output drops in the same delta as reset.
    run  = run_q & clr;
    if (run_q && clr) begin
      case (state)
        T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
        T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
        T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
        HALT: ;
        default: begin
          case (op)
            OP_LD, OP_ST, OP_LDI: begin
              case (state)
                T3: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                T4: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
                T5: begin
                  zlo_out = 1'b1;
                  if (op == OP_LDI) begin gra = 1'b1; r_in = 1'b1; end
                  else mar_enable = 1'b1;
                end
                T6: begin
                  mdr_enable = 1'b1;
                  if (op == OP_LD) read = 1'b1;
                  else begin gra = 1'b1; r_out = 1'b1; end
                end
                T7: begin
                  if (op == OP_LD) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                  else ram_write = 1'b1;
                end
                default: ;
              endcase
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
              case (state)
                T3: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                T4: begin
                  z_enable = 1'b1;
                  if (op == OP_ADDI) c_sign_extended_out = 1'b1;
                  else begin grc = 1'b1; r_out = 1'b1; end
                end
                T5: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                default: ;
              endcase
            end
            OP_BR: begin
              case (state)
                T3: begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                T4: begin pc_out = 1'b1; y_enable = 1'b1; end
                T5: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
                T6: begin zlo_out = 1'b1; pc_enable = con_out; end
                default: ;
              endcase
            end
            OP_JR:   if (state == T3) begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            OP_JAL: begin
              if (state == T3) begin pc_out = 1'b1; r15_enable = 1'b1; end
              if (state == T4) begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            end
            OP_IN:   if (state == T3) begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            OP_OUT:  if (state == T3) begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
            OP_MFHI: if (state == T3) begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            OP_MFLO: if (state == T3) begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven scoreboard bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_out;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out, r_out;
  logic mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, hi_enable, lo_enable;
  logic r15_enable, outport_enable, inport_enable, con_enable, r_in;
  logic pc_increment, read, ram_write, gra, grb, grc, run;
  logic [3:0] step;

  control_unit #(.OPW(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_out(con_out),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
    .mdr_out(mdr_out), .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
    .ba_out(ba_out), .r_out(r_out), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable), .pc_enable(pc_enable),
    .hi_enable(hi_enable), .lo_enable(lo_enable), .r15_enable(r15_enable),
    .outport_enable(outport_enable), .inport_enable(inport_enable), .con_enable(con_enable),
    .r_in(r_in), .pc_increment(pc_increment), .read(read), .ram_write(ram_write),
    .gra(gra), .grb(grb), .grc(grc), .run(run), .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [28:0] PC_OUT = 29'h1 << 0,  ZLO = 29'h1 << 1,  HI_OUT = 29'h1 << 3;
  localparam logic [28:0] LO_OUT = 29'h1 << 4,  MDR_OUT = 29'h1 << 5, INP_OUT = 29'h1 << 6;
  localparam logic [28:0] CSE = 29'h1 << 7,     BA = 29'h1 << 8,   R_OUT = 29'h1 << 9;
  localparam logic [28:0] MAR_EN = 29'h1 << 10, MDR_EN = 29'h1 << 11, IR_EN = 29'h1 << 12;
  localparam logic [28:0] Y_EN = 29'h1 << 13,   Z_EN = 29'h1 << 14, PC_EN = 29'h1 << 15;
  localparam logic [28:0] R15_EN = 29'h1 << 18, OUTP_EN = 29'h1 << 19, CON_EN = 29'h1 << 21;
  localparam logic [28:0] R_IN = 29'h1 << 22,   PC_INC = 29'h1 << 23, READ = 29'h1 << 24;
  localparam logic [28:0] RAM_W = 29'h1 << 25,  GRA = 29'h1 << 26, GRB = 29'h1 << 27;
  localparam logic [28:0] GRC = 29'h1 << 28;

  logic [28:0] ctrl;
  assign ctrl = {grc, grb, gra, ram_write, read, pc_increment, r_in, con_enable, inport_enable,
                 outport_enable, r15_enable, lo_enable, hi_enable, pc_enable, z_enable, y_enable,
                 ir_enable, mdr_enable, mar_enable, r_out, ba_out, c_sign_extended_out,
                 inport_out, mdr_out, lo_out, hi_out, zhi_out, zlo_out, pc_out};

  typedef struct {
    int          tag;
    logic [3:0]  stp;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name, input logic [3:0] exp_step);
    chk({name, "_step"}, 32'(step), 32'(exp_step));
    chk({name, "_run"}, 32'(run), 32'd0);
    chk({name, "_ctrl"}, 32'(ctrl), 32'd0);
  endtask

  task automatic add(input int tag, input logic [3:0] s, input logic [28:0] e);
    tbl.push_back('{tag, s, e});
  endtask

  // Fetch rows, then the execute rows of the tag, compared once per clock.
  // Returns with the DUT one cycle past the last row, or at the stop step.
  task automatic run_instr(input int tag, input logic [4:0] op, input logic c, input int stop);
    vec_t e;
    ir      = {op, 27'h0800005};
    con_out = c;
    sb.push_back('{-1, 4'd0, PC_OUT | MAR_EN | PC_INC | Z_EN});
    sb.push_back('{-1, 4'd1, ZLO | PC_EN | READ | MDR_EN});
    sb.push_back('{-1, 4'd2, MDR_OUT | IR_EN});
    foreach (tbl[i]) if (tbl[i].tag == tag) sb.push_back(tbl[i]);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("op%b_c%0d_T%0d_step", op, c, e.stp), 32'(step), 32'(e.stp));
      chk($sformatf("op%b_c%0d_T%0d_run", op, c, e.stp), 32'(run), 32'd1);
      chk($sformatf("op%b_c%0d_T%0d_ctrl", op, c, e.stp), 32'(ctrl), 32'(e.exp));
      if (int'(e.stp) == stop) begin
        sb.delete();
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0 ldi
    add(0, 3, GRB | BA | Y_EN);  add(0, 4, CSE | Z_EN);  add(0, 5, ZLO | GRA | R_IN);
    // 1 st
    add(1, 3, GRB | BA | Y_EN);  add(1, 4, CSE | Z_EN);  add(1, 5, ZLO | MAR_EN);
    add(1, 6, GRA | R_OUT | MDR_EN);  add(1, 7, RAM_W);
    // 2 br taken, 3 br not taken
    add(2, 3, GRA | R_OUT | CON_EN);  add(2, 4, PC_OUT | Y_EN);  add(2, 5, CSE | Z_EN);
    add(2, 6, ZLO | PC_EN);
    add(3, 3, GRA | R_OUT | CON_EN);  add(3, 4, PC_OUT | Y_EN);  add(3, 5, CSE | Z_EN);
    add(3, 6, ZLO);
    // 4 jr, 5 jal
    add(4, 3, GRA | R_OUT | PC_EN);
    add(5, 3, PC_OUT | R15_EN);  add(5, 4, GRA | R_OUT | PC_EN);
    // 6 sub (ALU group), 7 addi
    add(6, 3, GRB | R_OUT | Y_EN);  add(6, 4, GRC | R_OUT | Z_EN);  add(6, 5, ZLO | GRA | R_IN);
    add(7, 3, GRB | R_OUT | Y_EN);  add(7, 4, CSE | Z_EN);  add(7, 5, ZLO | GRA | R_IN);
    // 8 in, 9 out, 10 mfhi, 11 mflo
    add(8, 3, INP_OUT | GRA | R_IN);
    add(9, 3, GRA | R_OUT | OUTP_EN);
    add(10, 3, HI_OUT | GRA | R_IN);
    add(11, 3, LO_OUT | GRA | R_IN);
    // 14 ld
    add(14, 3, GRB | BA | Y_EN);  add(14, 4, CSE | Z_EN);  add(14, 5, ZLO | MAR_EN);
    add(14, 6, READ | MDR_EN);  add(14, 7, MDR_OUT | GRA | R_IN);

    clr = 1'b0;  ir = 32'h0;  con_out = 1'b0;
    @(negedge clk);
    chk_idle("reset", 4'd0);
    @(posedge clk); @(negedge clk);
    chk_idle("reset_held", 4'd0);
    clr = 1'b1;
    #1;
    chk_idle("released_before_edge", 4'd0);
    @(posedge clk); @(negedge clk);

    run_instr(0,  5'b00001, 1'b0, -1);
    run_instr(1,  5'b00010, 1'b0, -1);
    run_instr(2,  5'b10010, 1'b1, -1);
    run_instr(3,  5'b10010, 1'b0, -1);
    run_instr(4,  5'b10011, 1'b0, -1);
    run_instr(5,  5'b10100, 1'b0, -1);
    run_instr(6,  5'b00100, 1'b0, -1);
    run_instr(7,  5'b01000, 1'b0, -1);
    run_instr(8,  5'b10101, 1'b0, -1);
    run_instr(9,  5'b10110, 1'b0, -1);
    run_instr(10, 5'b10111, 1'b0, -1);
    run_instr(11, 5'b11000, 1'b0, -1);
    run_instr(12, 5'b11001, 1'b0, -1);
    run_instr(14, 5'b00000, 1'b0, -1);

    // halt holds for 10 clocks, then reset restarts fetch
    run_instr(13, 5'b11010, 1'b0, -1);
    for (int k = 0; k < 10; k++) begin
      chk_idle($sformatf("halt_%0d", k), 4'd15);
      @(posedge clk); @(negedge clk);
    end
    clr = 1'b0;
    #1;
    chk_idle("halt_clr", 4'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    run_instr(0, 5'b00001, 1'b0, -1);

    // reset in T6 of ld drops everything in the same timestep
    run_instr(14, 5'b00000, 1'b0, 6);
    clr = 1'b0;
    #1;
    chk_idle("ld_t6_clr", 4'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    run_instr(13, 5'b11111, 1'b0, -1);
    run_instr(0,  5'b00001, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
